// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Build option: define VEND_TIMEOUT_EN to enable the idle auto-return timer in vend_ctrl.
package vend_pkg;

    // Every price and coin value occupies one 16-bit field of its table.
    localparam int PRICE_W = 16;

    // Controller states: accepting credit/selections, or paying out change.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RETURN = 1'b1
    } state_t;

    // Default item prices, item 0 in the least significant field.
    localparam logic [4*PRICE_W-1:0] DEFAULT_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400};

    // Default coin values, coin 0 (smallest) in the least significant field.
    localparam logic [3*PRICE_W-1:0] DEFAULT_COINS = {16'd1000, 16'd500, 16'd100};

    // Number of bits needed to hold the value maxVal (at least one bit).
    function automatic int cnt_width(input int maxVal);
        int w;
        w = 1;
        while ((64'(1) << w) <= 64'(maxVal)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Change selector: picks the largest coin whose value does not exceed the
// remaining credit. Purely combinational; used by vend_ctrl while paying out.
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int NUM_COINS = 3,
    parameter int TOTAL_W   = 32
) (
    input  logic [TOTAL_W-1:0]           total_i,
    input  logic [NUM_COINS*PRICE_W-1:0] coinValue_i,
    output logic                         valid_o,
    output logic [NUM_COINS-1:0]         coinOneHot_o,
    output logic [PRICE_W-1:0]           coinAmount_o
);

    // Compare in a width that holds both operands without truncation.
    localparam int CMP_W = (TOTAL_W > PRICE_W) ? TOTAL_W : PRICE_W;

    // Coins are strictly ascending, so the last one that fits is the largest.
    always_comb begin
        valid_o      = 1'b0;
        coinOneHot_o = '0;
        coinAmount_o = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (CMP_W'(coinValue_i[i*PRICE_W +: PRICE_W]) <= CMP_W'(total_i)) begin
                valid_o         = 1'b1;
                coinOneHot_o    = '0;
                coinOneHot_o[i] = 1'b1;
                coinAmount_o    = coinValue_i[i*PRICE_W +: PRICE_W];
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coin credit, dispenses items while
// tracking per-item stock, and returns change one coin per cycle.
// Build option: define VEND_TIMEOUT_EN to add an idle timer that starts the
// change return automatically after WAIT_CYCLES quiet cycles with credit.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS   = 4,
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_W     = 32,
    parameter int STOCK_W     = 8,
    parameter int STOCK_INIT  = 10,
    parameter int WAIT_CYCLES = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_ITEMS*PRICE_W-1:0] i_price,
    input  logic [NUM_COINS*PRICE_W-1:0] i_coin_value,
    input  logic [NUM_COINS-1:0]         i_input_coin,
    input  logic [NUM_ITEMS-1:0]         i_select_item,
    input  logic                         i_trigger_return,
    input  logic                         i_restock,
    output logic [NUM_ITEMS-1:0]         o_available_item,
    output logic [NUM_ITEMS-1:0]         o_output_item,
    output logic [NUM_COINS-1:0]         o_return_coin,
    output logic [TOTAL_W-1:0]           o_current_total,
    output logic                         o_busy,
    output logic                         o_reject
);

    // Wide enough for the current total plus every coin inserted at once.
    localparam int EXT_W = TOTAL_W + PRICE_W + $clog2(NUM_COINS + 1);

    state_t               state_q;
    logic [TOTAL_W-1:0]   total_q;
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] outputItem_q;
    logic [NUM_COINS-1:0] returnCoin_q;
    logic                 reject_q;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = cnt_width(WAIT_CYCLES);
    logic [TMO_W-1:0]     timeoutCnt_q;
`endif

    logic [PRICE_W-1:0]   itemPrice [NUM_ITEMS];
    logic [EXT_W-1:0]     coinSum;
    logic [EXT_W-1:0]     creditSum;
    logic                 coinOverflow;
    logic                 anyCoin;
    logic                 anySelect;
    logic                 pickFound;
    logic [NUM_ITEMS-1:0] pickOneHot;
    logic [PRICE_W-1:0]   pickPrice;
    logic                 changeValid;
    logic [NUM_COINS-1:0] changeOneHot;
    logic [PRICE_W-1:0]   changeAmount;

    // Unpack the flat price table into one entry per item.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            itemPrice[i] = i_price[i*PRICE_W +: PRICE_W];
        end
    end

    // Sum all coins inserted this cycle; any carry past TOTAL_W means refusal.
    always_comb begin
        coinSum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (i_input_coin[i]) begin
                coinSum = coinSum + EXT_W'(i_coin_value[i*PRICE_W +: PRICE_W]);
            end
        end
        creditSum    = EXT_W'(total_q) + coinSum;
        coinOverflow = |creditSum[EXT_W-1:TOTAL_W];
        anyCoin      = |i_input_coin;
        anySelect    = |i_select_item;
    end

    // An item is purchasable when credit covers its price and it is in stock.
    always_comb begin
        o_available_item = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            o_available_item[i] = (EXT_W'(total_q) >= EXT_W'(itemPrice[i]))
                                  && (stock_q[i] != '0);
        end
    end

    // Lowest-index requested item that is currently purchasable.
    always_comb begin
        pickFound  = 1'b0;
        pickOneHot = '0;
        pickPrice  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!pickFound && i_select_item[i] && o_available_item[i]) begin
                pickFound     = 1'b1;
                pickOneHot[i] = 1'b1;
                pickPrice     = itemPrice[i];
            end
        end
    end

    vend_change_sel #(
        .NUM_COINS (NUM_COINS),
        .TOTAL_W   (TOTAL_W)
    ) u_change_sel (
        .total_i      (total_q),
        .coinValue_i  (i_coin_value),
        .valid_o      (changeValid),
        .coinOneHot_o (changeOneHot),
        .coinAmount_o (changeAmount)
    );

    // Main FSM: credit, dispensing, stock and the change payout. The first
    // change coin is paid on the edge that enters RETURN, so o_busy lasts
    // exactly one cycle longer than the last pulse's subtraction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            total_q      <= '0;
            outputItem_q <= '0;
            returnCoin_q <= '0;
            reject_q     <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
`ifdef VEND_TIMEOUT_EN
            timeoutCnt_q <= '0;
`endif
        end else begin
            outputItem_q <= '0;
            returnCoin_q <= '0;
            reject_q     <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timeoutCnt_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (anyCoin) begin
                        if (coinOverflow) begin
                            reject_q <= 1'b1;
                        end else begin
                            total_q <= creditSum[TOTAL_W-1:0];
                        end
                    end else if (anySelect) begin
                        if (pickFound) begin
                            outputItem_q <= pickOneHot;
                            total_q      <= total_q - TOTAL_W'(pickPrice);
                            for (int i = 0; i < NUM_ITEMS; i++) begin
                                if (pickOneHot[i]) begin
                                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                                end
                            end
                        end
                    end else if (i_trigger_return) begin
                        if (changeValid) begin
                            state_q      <= ST_RETURN;
                            returnCoin_q <= changeOneHot;
                            total_q      <= total_q - TOTAL_W'(changeAmount);
                        end
                    end else if (i_restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            stock_q[i] <= STOCK_W'(STOCK_INIT);
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (changeValid) begin
                        if (timeoutCnt_q == TMO_W'(WAIT_CYCLES - 1)) begin
                            state_q      <= ST_RETURN;
                            returnCoin_q <= changeOneHot;
                            total_q      <= total_q - TOTAL_W'(changeAmount);
                        end else begin
                            timeoutCnt_q <= timeoutCnt_q + TMO_W'(1);
                        end
                    end
`endif
                end
                ST_RETURN: begin
                    if (anyCoin) begin
                        reject_q <= 1'b1;
                    end
                    if (changeValid) begin
                        returnCoin_q <= changeOneHot;
                        total_q      <= total_q - TOTAL_W'(changeAmount);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_output_item   = outputItem_q;
    assign o_return_coin   = returnCoin_q;
    assign o_reject        = reject_q;
    assign o_current_total = total_q;
    assign o_busy          = (state_q == ST_RETURN);

endmodule
